// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one registered sprite ROM among NUM_REQ pixel requesters; grant is combinational.
// Response tagged with requester id appears ROM_LAT cycles after the transfer; no backpressure on responses.
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 3,
   parameter int ROM_LAT = 1
) (
   input  logic                        vga_clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]           rom_address,
   input  logic [DATA_W-1:0]           rom_q,
   output logic                        rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [NUM_REQ-1:0]          starve
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int SUM_W = ID_W + 1;
   localparam int CNT_W = $clog2(NUM_REQ + 1);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
   localparam logic [SUM_W-1:0] NREQ_S  = SUM_W'(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REQ);

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   tag_t              pipe_q [ROM_LAT];
   tag_t              pipe_d [ROM_LAT];
   logic [CNT_W-1:0]  wait_q [NUM_REQ];
   logic [CNT_W-1:0]  wait_d [NUM_REQ];
   logic [NUM_REQ-1:0] starve_q, starve_d;

   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic [ADDR_W-1:0] win_addr;

   // Search upward from ptr; the wrap is mod NUM_REQ so non-power-of-two counts work.
   always_comb begin
      logic [SUM_W-1:0] cand;
      logic [ID_W-1:0]  cand_id;
      cand    = '0;
      cand_id = '0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + SUM_W'(k);
         if (cand >= NREQ_S) begin
            cand = cand - NREQ_S;
         end
         cand_id = cand[ID_W-1:0];
         if (!win_vld && req[cand_id]) begin
            win_vld = 1'b1;
            win_id  = cand_id;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (win_vld) begin
         gnt[win_id] = 1'b1;
      end
      win_addr = req_addr[win_id*ADDR_W +: ADDR_W];
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      if (win_vld) begin
         ptr_d  = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
         addr_d = win_addr;
      end
      // Idle cycles keep the last granted address on the ROM bus.
      rom_address = win_vld ? win_addr : addr_q;
   end

   always_comb begin
      pipe_d[0].vld = win_vld;
      pipe_d[0].id  = win_id;
      for (int s = 1; s < ROM_LAT; s++) begin
         pipe_d[s] = pipe_q[s-1];
      end
   end

   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = '0;
         if (req[i] && !gnt[i]) begin
            wait_d[i] = (wait_q[i] == CNT_MAX) ? CNT_MAX : wait_q[i] + CNT_W'(1);
         end
         if (wait_d[i] == CNT_MAX) begin
            starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         ptr_q    <= '0;
         addr_q   <= '0;
         starve_q <= '0;
         for (int s = 0; s < ROM_LAT; s++) begin
            pipe_q[s] <= '0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         starve_q <= starve_d;
         for (int s = 0; s < ROM_LAT; s++) begin
            pipe_q[s] <= pipe_d[s];
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign rsp_valid = pipe_q[ROM_LAT-1].vld;
   assign rsp_id    = pipe_q[ROM_LAT-1].id;
   assign rsp_data  = rom_q;
   assign starve    = starve_q;

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM (registered `q`) between up to NUM_REQ pixel-pipeline requesters, e.g. spike, block and player renderers, in the VGA clock domain. Each cycle at most one request is granted by round-robin. Its address is driven to the ROM, and the returned data comes back tagged with the requester index after the ROM read latency. The block sits between the per-object draw logic and the shared ROM/palette pair.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, 2..8.
- ADDR_W, default 10: ROM address width.
- DATA_W, default 3: ROM word (palette index) width.
- ROM_LAT, default 1: ROM read latency in cycles, 1..3.

Ports:
- vga_clk  in  1: sole clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- req  in  NUM_REQ: request level per requester.
- req_addr  in  NUM_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ: one-hot combinational grant; a transfer occurs when req[i] and gnt[i] are both high at a rising edge.
- rom_address  out  ADDR_W: address to the shared ROM, combinational from the winning req_addr.
- rom_q  in  DATA_W: ROM output, valid ROM_LAT cycles after the address is presented.
- rsp_valid  out  1: response valid.
- rsp_id  out  $clog2(NUM_REQ): index of the requester that owns rsp_data.
- rsp_data  out  DATA_W: equals rom_q; qualified by rsp_valid.
- starve  out  NUM_REQ: sticky flag per requester, set when its req has waited NUM_REQ or more cycles without a grant.

## Operation
- **Arbitration:** round-robin pointer `ptr` (registered).
  - Search req starting at index ptr and wrapping upward; the first set bit wins.
  - gnt is one-hot on the winner, or all-zero if req==0.
- **Pointer update:** on a transfer, ptr <= (winner+1) mod NUM_REQ. With no transfer, ptr holds.
- **Address:** rom_address = req_addr slice of the winner. With no winner it holds the last granted address; no glitching to a new value.
- **Response pipeline:** a ROM_LAT-deep shift register of {valid, id}.
  - Stage 0 loads {1, winner} on a transfer and {0, x} otherwise.
  - rsp_valid/rsp_id are taken from the last stage. rsp_data = rom_q directly.
- **Requester protocol:**
  - Hold req and req_addr stable until gnt is seen.
  - Deassert req, or present a new address, in the cycle after the grant.
  - The arbiter does not enforce this; re-asserting req simply issues another read.
- **Starvation monitor:**
  - One wait counter per requester, saturating at NUM_REQ.
  - The counter increments when req[i] & ~gnt[i], and clears on a grant or when req[i]=0.
  - starve[i] sets when the counter reaches NUM_REQ and stays set until reset.
  - Round-robin guarantees starve stays 0 under a legal protocol; the verifier treats any set bit as a failure.
- **Width rules:**
  - ptr and rsp_id are $clog2(NUM_REQ) bits.
  - The wrap is computed mod NUM_REQ, not mod 2^width; NUM_REQ need not be a power of two.

## Timing
- **Reset values (async assert, sync release):** ptr=0, rom_address=0, all pipeline valid bits 0, rsp_valid=0, rsp_id=0, wait counters 0, starve=0. gnt is combinational from req and ptr, so it follows req even during reset.
- **Throughput:** one grant per cycle; back-to-back grants to different requesters every cycle.
- **Latency:** a transfer at edge T gives rsp_valid=1 at edge T+ROM_LAT.
  - rsp_id is aligned with that rom_q.
  - Responses return in grant order; they never reorder or drop.
- **Simultaneous events:**
  - All req high: grants rotate ptr, ptr+1, … one per cycle.
  - A single requester holding req continuously is granted every cycle.
- **Reset mid-operation:** in-flight pipeline entries are discarded (rsp_valid=0 from reset assertion). No response is produced for grants issued before reset.

## Test plan
- **Reset:** assert reset mid-stream with two reads in flight (ROM_LAT=2) -> rsp_valid drops to 0 immediately; no stale response after release; ptr restarts at 0.
- **Single requester:** req=4'b0100, addr 10'd37 -> gnt=4'b0100 the same cycle. One cycle later (ROM_LAT=1): rsp_valid=1, rsp_id=2, rsp_data = ROM[37].
- **Full contention:** req=4'b1111 held for 8 cycles, distinct addresses -> gnt sequence 0,1,2,3,0,1,2,3. Responses carry matching ids and data in the same order; starve stays 0.
- **Pointer wrap, non-power-of-two:** NUM_REQ=3, ptr=2, req=3'b011 -> requester 0 wins and ptr becomes 1. The next cycle with req=3'b011 -> requester 1 wins.
- **Idle gaps:** req pattern 1000, 0000, 0000, 0001 -> gnt only in cycles 0 and 3. rom_address holds the cycle-0 address through cycles 1-2. Exactly two responses (ids 3 and 0).
- **Latency sweep:** ROM_LAT = 1, 2 and 3 with a random req stream against a scoreboard model -> every grant yields exactly one response after ROM_LAT cycles, with the correct id/data and in order.
